// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// fetch_entry_t gains a misalign flag when IF_MISALIGN_TRAP_EN is defined.
package if_fetch_unit_pkg;

    localparam int              XLEN      = 32;
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
`ifdef IF_MISALIGN_TRAP_EN
        logic            misalign;
`endif
    } fetch_entry_t;

    // Sequential fetch address; wraps modulo 2^XLEN
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush (clear), push, pop and occupancy count.
// A clear in the same cycle as a push leaves exactly the pushed entry.
module if_fetch_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  fetch_entry_t     push_data,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_pop_s;
    logic             do_push_s;
    logic [PTR_W-1:0] wr_idx_s;

    // Qualify push/pop; a flush restarts writing at slot zero
    always_comb begin
        do_pop_s  = pop && (count_r != '0) && !clear;
        do_push_s = push && (clear || do_pop_s || (count_r != CNT_W'(DEPTH)));
        if (clear) begin
            wr_idx_s = '0;
        end else begin
            wr_idx_s = wr_ptr_r;
        end
        head  = mem_r[rd_ptr_r];
        count = count_r;
    end

    // Pointer and occupancy state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (clear) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= do_push_s ? PTR_W'(1) : '0;
            count_r  <= do_push_s ? CNT_W'(1) : '0;
        end else begin
            if (do_pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_idx_s] <= push_data;
    end

    if_fetch_fifo_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .clear  (clear),
        .do_pop (do_pop_s),
        .count  (count_r)
    );

endmodule

// File: rtl/if_fetch_fifo_chk.sv
// Protocol checker for the fetch response queue: a push must never land on a full queue.
module if_fetch_fifo_chk #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input logic             clk,
    input logic             rst_n,
    input logic             push,
    input logic             clear,
    input logic             do_pop,
    input logic [CNT_W-1:0] count
);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !clear && !do_pop && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: credit-limited in-order fetch, response queue, redirect flush.
// Optional IF_MISALIGN_TRAP_EN turns misaligned redirects into a flagged NOP and halts fetch.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_resp_valid_i,
    input  logic [XLEN-1:0] imem_resp_data_i,
`ifdef IF_MISALIGN_TRAP_EN
    output logic            if_misalign_o,
`endif
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_instr_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0]  fetch_pc_r;
    logic [XLEN-1:0]  resp_pc_r;
    logic [XLEN-1:0]  target_pc_s;
    logic [CNT_W-1:0] outstanding_r;
    logic [CNT_W-1:0] drop_cnt_r;
    logic [CNT_W-1:0] fifo_count_s;
    logic [CNT_W:0]   credit_used_s;
    logic             issue_s;
    logic             accept_resp_s;
    logic             push_s;
    logic             pop_s;
    logic             trap_s;
    logic             halted_s;
    fetch_entry_t     push_entry_s;
    fetch_entry_t     head_s;
`ifdef IF_MISALIGN_TRAP_EN
    logic             halted_r;
`endif

    // Redirect target, misalignment trap and fetch halt
    always_comb begin
`ifdef IF_MISALIGN_TRAP_EN
        target_pc_s = redirect_pc_i;
        trap_s      = redirect_i && (redirect_pc_i[1:0] != 2'b00);
        halted_s    = halted_r;
`else
        target_pc_s = {redirect_pc_i[XLEN-1:2], 2'b00};
        trap_s      = 1'b0;
        halted_s    = 1'b0;
`endif
    end

    // Request credit, response acceptance, queue push/pop and head presentation
    always_comb begin
        credit_used_s    = {1'b0, outstanding_r} + {1'b0, fifo_count_s};
        imem_req_valid_o = rst_n && !redirect_i && !halted_s &&
                           (credit_used_s < (CNT_W + 1)'(FIFO_DEPTH));
        imem_req_addr_o  = fetch_pc_r;
        issue_s          = imem_req_valid_o && imem_req_ready_i;
        accept_resp_s    = imem_resp_valid_i && (drop_cnt_r == '0) && !redirect_i;
        if_valid_o       = (fifo_count_s != '0);
        pop_s            = if_valid_o && !stall_i && !redirect_i;
        push_entry_s     = '0;
        if (trap_s) begin
            push_s             = 1'b1;
            push_entry_s.pc    = redirect_pc_i;
            push_entry_s.instr = NOP_INSTR;
`ifdef IF_MISALIGN_TRAP_EN
            push_entry_s.misalign = 1'b1;
`endif
        end else begin
            push_s             = accept_resp_s;
            push_entry_s.pc    = resp_pc_r;
            push_entry_s.instr = imem_resp_data_i;
        end
        if (if_valid_o) begin
            if_pc_o    = head_s.pc;
            if_instr_o = head_s.instr;
        end else begin
            if_pc_o    = '0;
            if_instr_o = '0;
        end
`ifdef IF_MISALIGN_TRAP_EN
        if_misalign_o = if_valid_o && head_s.misalign;
`endif
    end

    // Fetch/response PCs plus outstanding and stale-response counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= '0;
            drop_cnt_r    <= '0;
        end else if (redirect_i) begin
            // every request still in flight after this cycle is stale
            fetch_pc_r    <= target_pc_s;
            resp_pc_r     <= target_pc_s;
            outstanding_r <= outstanding_r - CNT_W'(imem_resp_valid_i);
            drop_cnt_r    <= outstanding_r - CNT_W'(imem_resp_valid_i);
        end else begin
            if (issue_s) fetch_pc_r <= next_pc(fetch_pc_r);
            if (accept_resp_s) resp_pc_r <= next_pc(resp_pc_r);
            outstanding_r <= outstanding_r + CNT_W'(issue_s) - CNT_W'(imem_resp_valid_i);
            if (imem_resp_valid_i && (drop_cnt_r != '0)) drop_cnt_r <= drop_cnt_r - CNT_W'(1);
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    // Fetch halts after a misaligned redirect until the next redirect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halted_r <= 1'b0;
        end else if (redirect_i) begin
            halted_r <= trap_s;
        end
    end
`endif

    if_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (redirect_i),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (push_entry_s),
        .head      (head_s),
        .count     (fifo_count_s)
    );

endmodule
